// File: rtl/bel_fft_seq.sv
// bel_fft_seq: autonomous register sequencer for the bel_fft core.
// Acts as an Avalon-MM master: programs size/src/dst/factors, verifies each
// factor by readback, starts the core, waits for its interrupt (with an
// optional timeout) and reads the status register.
module bel_fft_seq #(
    parameter int SIF_AWIDTH = 4,
    parameter int DWIDTH     = 32,
    parameter int BCNT       = 4,
    parameter int SIZE_ADDR  = 2,
    parameter int SRC_ADDR   = 3,
    parameter int DST_ADDR   = 4,
    parameter int FAC_ADDR   = 8,
    parameter int CTRL_ADDR  = 0,
    parameter int STAT_ADDR  = 1,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [DWIDTH-1:0]       size_i,
    input  logic [DWIDTH-1:0]       src_i,
    input  logic [DWIDTH-1:0]       dst_i,
    input  logic                    inverse_i,
    input  logic [2:0]              nfac_i,
    input  logic [4*DWIDTH-1:0]     fac_i,
    output logic [SIF_AWIDTH-1:0]   m_address,
    output logic [DWIDTH-1:0]       m_writedata,
    output logic [BCNT-1:0]         m_byteenable,
    output logic                    m_read,
    output logic                    m_write,
    input  logic                    m_waitrequest,
    input  logic [DWIDTH-1:0]       m_readdata,
    input  logic                    m_readdatavalid,
    input  logic                    int_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DWIDTH-1:0]       status_o,
    output logic [1:0]              err_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ILLEGAL, S_WR_SIZE, S_WR_SRC, S_WR_DST, S_WR_FAC,
        S_RD_FAC, S_WR_CTRL, S_WAIT_INT, S_RD_STAT, S_DONE
    } state_t;

    // ISSUE: request not yet driven; REQ: request on the bus; RDV: waiting read data
    typedef enum logic [1:0] {PH_ISSUE, PH_REQ, PH_RDV} phase_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
    localparam bit          TO_EN   = (TIMEOUT != 0);

    state_t                  state_q, state_d;
    phase_t                  phase_q, phase_d;
    logic [1:0]              fac_idx_q, fac_idx_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [DWIDTH-1:0]       size_q, size_d, src_q, src_d, dst_q, dst_d;
    logic                    inv_q, inv_d;
    logic [2:0]              nfac_q, nfac_d;
    logic [4*DWIDTH-1:0]     fac_q, fac_d;
    logic [SIF_AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]       wdata_q, wdata_d;
    logic [BCNT-1:0]         be_q, be_d;
    logic                    rd_q, rd_d, wr_q, wr_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [DWIDTH-1:0]       status_q, status_d;
    logic [1:0]              err_q, err_d;
    logic                    int_q, int_prev_q;

    logic [SIF_AWIDTH-1:0]   acc_addr_s;
    logic [DWIDTH-1:0]       acc_data_s;
    logic                    acc_is_rd_s;
    state_t                  acc_next_s;
    logic [DWIDTH-1:0]       fac_sel_s;
    logic                    fac_last_s;
    logic                    int_rise_s;

    assign fac_sel_s  = fac_q[32'(fac_idx_q) * DWIDTH +: DWIDTH];
    assign fac_last_s = ({1'b0, fac_idx_q} == (nfac_q - 3'd1));
    assign int_rise_s = int_q & ~int_prev_q;

    // Describe the bus access belonging to the current state
    always_comb begin
        acc_addr_s  = '0;
        acc_data_s  = '0;
        acc_is_rd_s = 1'b0;
        acc_next_s  = S_IDLE;
        case (state_q)
            S_WR_SIZE: begin
                acc_addr_s = SIF_AWIDTH'(SIZE_ADDR);
                acc_data_s = size_q;
                acc_next_s = S_WR_SRC;
            end
            S_WR_SRC: begin
                acc_addr_s = SIF_AWIDTH'(SRC_ADDR);
                acc_data_s = src_q;
                acc_next_s = S_WR_DST;
            end
            S_WR_DST: begin
                acc_addr_s = SIF_AWIDTH'(DST_ADDR);
                acc_data_s = dst_q;
                acc_next_s = S_WR_FAC;
            end
            S_WR_FAC: begin
                acc_addr_s = SIF_AWIDTH'(FAC_ADDR) + SIF_AWIDTH'(fac_idx_q);
                acc_data_s = fac_sel_s;
                acc_next_s = S_RD_FAC;
            end
            S_RD_FAC: begin
                acc_addr_s  = SIF_AWIDTH'(FAC_ADDR) + SIF_AWIDTH'(fac_idx_q);
                acc_is_rd_s = 1'b1;
            end
            S_WR_CTRL: begin
                // bit 16 = inverse, bit 8 and bit 0 = enable/start
                acc_addr_s = SIF_AWIDTH'(CTRL_ADDR);
                acc_data_s = DWIDTH'({15'b0, inv_q, 7'b0, 1'b1, 7'b0, 1'b1});
                acc_next_s = S_WAIT_INT;
            end
            S_RD_STAT: begin
                acc_addr_s  = SIF_AWIDTH'(STAT_ADDR);
                acc_is_rd_s = 1'b1;
            end
            default: begin
                acc_addr_s = '0;
            end
        endcase
    end

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        fac_idx_d = fac_idx_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        src_d     = src_q;
        dst_d     = dst_q;
        inv_d     = inv_q;
        nfac_d    = nfac_q;
        fac_d     = fac_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        status_d  = status_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    size_d    = size_i;
                    src_d     = src_i;
                    dst_d     = dst_i;
                    inv_d     = inverse_i;
                    nfac_d    = nfac_i;
                    fac_d     = fac_i;
                    err_d     = 2'd0;
                    fac_idx_d = 2'd0;
                    phase_d   = PH_ISSUE;
                    if ((nfac_i == 3'd0) || (nfac_i > 3'd4)) begin
                        state_d = S_ILLEGAL;
                    end else begin
                        state_d = S_WR_SIZE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ILLEGAL: begin
                err_d   = 2'd3;
                state_d = S_DONE;
            end
            S_WR_SIZE, S_WR_SRC, S_WR_DST, S_WR_FAC, S_RD_FAC, S_WR_CTRL, S_RD_STAT: begin
                case (phase_q)
                    PH_ISSUE: begin
                        addr_d  = acc_addr_s;
                        wdata_d = acc_is_rd_s ? '0 : acc_data_s;
                        wr_d    = ~acc_is_rd_s;
                        rd_d    = acc_is_rd_s;
                        be_d    = '1;
                        phase_d = PH_REQ;
                    end
                    PH_REQ: begin
                        if (!m_waitrequest) begin
                            rd_d = 1'b0;
                            wr_d = 1'b0;
                            be_d = '0;
                            if (acc_is_rd_s) begin
                                phase_d = PH_RDV;
                            end else begin
                                phase_d = PH_ISSUE;
                                state_d = acc_next_s;
                                cnt_d   = 32'd0;
                            end
                        end else begin
                            phase_d = PH_REQ;
                        end
                    end
                    PH_RDV: begin
                        if (m_readdatavalid) begin
                            phase_d = PH_ISSUE;
                            if (state_q == S_RD_STAT) begin
                                status_d = m_readdata;
                                state_d  = S_DONE;
                            end else if (m_readdata != fac_sel_s) begin
                                err_d   = 2'd1;
                                state_d = S_DONE;
                            end else if (fac_last_s) begin
                                state_d = S_WR_CTRL;
                            end else begin
                                fac_idx_d = fac_idx_q + 2'd1;
                                state_d   = S_WR_FAC;
                            end
                        end else begin
                            phase_d = PH_RDV;
                        end
                    end
                    default: begin
                        phase_d = PH_ISSUE;
                    end
                endcase
            end
            S_WAIT_INT: begin
                if (int_rise_s) begin
                    phase_d = PH_ISSUE;
                    state_d = S_RD_STAT;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    err_d   = 2'd2;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_ISSUE;
            fac_idx_q  <= 2'd0;
            cnt_q      <= 32'd0;
            size_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            inv_q      <= 1'b0;
            nfac_q     <= 3'd0;
            fac_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= '0;
            err_q      <= 2'd0;
            int_q      <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            fac_idx_q  <= fac_idx_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            inv_q      <= inv_d;
            nfac_q     <= nfac_d;
            fac_q      <= fac_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            status_q   <= status_d;
            err_q      <= err_d;
            int_q      <= int_i;
            int_prev_q <= int_q;
        end
    end

    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign m_byteenable = be_q;
    assign m_read       = rd_q;
    assign m_write      = wr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign status_o     = status_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_bel_fft_seq.sv
// Testbench for bel_fft_seq: Avalon slave model with configurable stalls,
// access monitor feeding an observed queue, scenario tasks comparing it
// against an expected queue built when the stimulus is driven.
module tb_bel_fft_seq;

    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [31:0]  size_i = 32'd0, src_i = 32'd0, dst_i = 32'd0;
    logic         inverse_i = 1'b0;
    logic [2:0]   nfac_i = 3'd0;
    logic [127:0] fac_i = 128'd0;
    logic [3:0]   m_address;
    logic [31:0]  m_writedata;
    logic [3:0]   m_byteenable;
    logic         m_read, m_write, m_waitrequest;
    logic [31:0]  m_readdata;
    logic         m_readdatavalid;
    logic         int_i = 1'b0;
    logic         busy_o, done_o;
    logic [31:0]  status_o;
    logic [1:0]   err_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bel_fft_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .size_i(size_i), .src_i(src_i),
        .dst_i(dst_i), .inverse_i(inverse_i), .nfac_i(nfac_i), .fac_i(fac_i),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .int_i(int_i),
        .busy_o(busy_o), .done_o(done_o), .status_o(status_o), .err_o(err_o)
    );

    // ---------------- slave model ----------------
    int          wait_n = 0;
    logic        stall9 = 1'b0;
    logic        corrupt_en = 1'b0;
    logic [3:0]  corrupt_addr = 4'd0;
    logic [31:0] stat_val = 32'd0;
    logic [31:0] mem [16];
    int          wcnt;
    logic        rd_pend;
    int          rd_cnt;
    logic [31:0] rd_data;

    assign m_waitrequest = (m_read | m_write) &&
                           ((wcnt < wait_n) || (stall9 && (m_address == 4'd9)));

    // Slave: stall counter, register file, delayed read data
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt            <= 0;
            rd_pend         <= 1'b0;
            rd_cnt          <= 0;
            rd_data         <= 32'd0;
            m_readdatavalid <= 1'b0;
            m_readdata      <= 32'd0;
        end else begin
            m_readdatavalid <= 1'b0;
            if ((m_read | m_write) && m_waitrequest) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (m_write && !m_waitrequest) mem[m_address] <= m_writedata;
            if (m_read && !m_waitrequest) begin
                rd_pend <= 1'b1;
                rd_cnt  <= 1;
                rd_data <= (m_address == 4'd1) ? stat_val :
                           (corrupt_en && (m_address == corrupt_addr)) ? 32'h00040005 :
                           mem[m_address];
            end else if (rd_pend) begin
                if (rd_cnt == 0) begin
                    m_readdatavalid <= 1'b1;
                    m_readdata      <= rd_data;
                    rd_pend         <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        int          hold;
        logic        stable;
    } acc_t;

    acc_t        obs_q[$];
    acc_t        exp_q[$];
    int          cyc = 0;
    int          done_cnt = 0;
    logic        both_hi = 1'b0;
    logic        in_acc = 1'b0;
    int          hold = 0;
    logic [3:0]  a0 = 4'd0;
    logic [31:0] d0 = 32'd0;
    logic        w0 = 1'b0;
    logic        stab = 1'b1;
    logic        same_s;
    logic        be_ok_s;

    assign same_s  = (m_address == a0) && (m_writedata == d0) && (m_write == w0);
    assign be_ok_s = (m_byteenable == 4'hF);

    // Monitor: record each accepted access with its hold length and stability
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (done_o) done_cnt <= done_cnt + 1;
        if (m_read && m_write) both_hi <= 1'b1;
        if (rst) begin
            in_acc <= 1'b0;
        end else if (m_read || m_write) begin
            if (m_waitrequest) begin
                in_acc <= 1'b1;
                hold   <= in_acc ? hold + 1 : 1;
                if (!in_acc) begin
                    a0 <= m_address; d0 <= m_writedata; w0 <= m_write; stab <= be_ok_s;
                end else begin
                    stab <= stab && same_s && be_ok_s;
                end
            end else begin
                in_acc <= 1'b0;
                obs_q.push_back('{m_write, m_address, m_writedata,
                                  in_acc ? hold + 1 : 1,
                                  in_acc ? (stab && same_s && be_ok_s) : be_ok_s});
            end
        end else begin
            in_acc <= 1'b0;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({busy_o, done_o, err_o, m_read, m_write, m_byteenable, m_address} !== 13'd0 ||
            status_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0d rd=%0b wr=%0b be=%0h addr=%0h status=%0h want all 0",
                     busy_o, done_o, err_o, m_read, m_write, m_byteenable, m_address, status_o);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy_o !== 1'b0) begin fails++; $display("FAIL idle_busy: got %0b want 0", busy_o); end
    endtask

    // ck = factor index whose readback is corrupted (-1 none)
    task automatic run_seq(input string nm, input int wn, input int ck, input bit give_int,
                           input bit start_in_wait, input bit inv, input int nf,
                           input logic [31:0] stat);
        logic [31:0] f [4];
        logic [1:0]  exp_err;
        int          ccyc, dcyc, dc0, n;
        bit          seen;
        f[0] = 32'h00040040; f[1] = 32'h00040010; f[2] = 32'h00040004; f[3] = 32'h00040001;
        wait_n = wn; corrupt_en = (ck >= 0); corrupt_addr = 4'(8 + ck); stat_val = stat;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back('{1'b1, 4'd2, 32'd256, 0, 1'b1});
        exp_q.push_back('{1'b1, 4'd3, 32'h800, 0, 1'b1});
        exp_q.push_back('{1'b1, 4'd4, 32'h1000, 0, 1'b1});
        for (int k = 0; k < nf; k++) begin
            exp_q.push_back('{1'b1, 4'(8 + k), f[k], 0, 1'b1});
            exp_q.push_back('{1'b0, 4'(8 + k), 32'd0, 0, 1'b1});
            if (k == ck) break;
        end
        if (ck < 0) begin
            exp_q.push_back('{1'b1, 4'd0, inv ? 32'h00010101 : 32'h00000101, 0, 1'b1});
            if (give_int) exp_q.push_back('{1'b0, 4'd1, 32'd0, 0, 1'b1});
        end
        exp_err = (ck >= 0) ? 2'd1 : (give_int ? 2'd0 : 2'd2);
        dc0 = done_cnt;
        ccyc = 0; dcyc = 0;

        @(negedge clk);
        size_i = 32'd256; src_i = 32'h800; dst_i = 32'h1000; inverse_i = inv;
        nfac_i = 3'(nf); fac_i = {f[3], f[2], f[1], f[0]}; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        tests++;
        if (busy_o !== 1'b1 || err_o !== 2'd0) begin
            fails++;
            $display("FAIL %s_start: got busy=%0b err=%0d want busy=1 err=0", nm, busy_o, err_o);
        end

        if (ck < 0) begin
            seen = 0;
            for (int i = 0; i < 2000 && !seen; i++) begin
                @(negedge clk);
                if (m_write && m_address == 4'd0 && !m_waitrequest) begin seen = 1; ccyc = cyc; end
            end
            tests++;
            if (!seen) begin fails++; $display("FAIL %s_ctrl_wait: got no control write want one", nm); end
            if (start_in_wait) begin
                @(negedge clk); nfac_i = 3'd0; start_i = 1'b1;
                @(negedge clk); start_i = 1'b0; nfac_i = 3'(nf);
            end
            if (give_int) begin
                repeat (3) @(negedge clk);
                int_i = 1'b1;
                repeat (2) @(negedge clk);
                int_i = 1'b0;
            end
        end

        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done_o) begin seen = 1; dcyc = cyc; end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL %s_done_wait: got no done_o want pulse", nm); end
        tests++;
        if (err_o !== exp_err || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_state: got err=%0d busy=%0b want err=%0d busy=0", nm, err_o, busy_o, exp_err);
        end
        if (ck < 0 && !give_int) begin
            tests++;
            if (dcyc - ccyc != TO + 1) begin
                fails++;
                $display("FAIL %s_timeout_len: got %0d want %0d cycles after entry", nm, dcyc - ccyc - 1, TO);
            end
        end
        if (give_int && ck < 0) begin
            tests++;
            if (status_o !== stat) begin fails++; $display("FAIL %s_status: got %0h want %0h", nm, status_o, stat); end
        end
        @(negedge clk);
        tests++;
        if (done_o !== 1'b0) begin fails++; $display("FAIL %s_done_width: got done=%0b want 0", nm, done_o); end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt - dc0 != 1) begin fails++; $display("FAIL %s_done_count: got %0d want 1", nm, done_cnt - dc0); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s_access_count: got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            tests++;
            if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].wr && obs_q[i].data !== exp_q[i].data) ||
                obs_q[i].hold != wn + 1 || obs_q[i].stable !== 1'b1) begin
                fails++;
                $display("FAIL %s_access%0d: got wr=%0b addr=%0d data=%0h hold=%0d stable=%0b want wr=%0b addr=%0d data=%0h hold=%0d stable=1",
                         nm, i, obs_q[i].wr, obs_q[i].addr, obs_q[i].data, obs_q[i].hold, obs_q[i].stable,
                         exp_q[i].wr, exp_q[i].addr, exp_q[i].data, wn + 1);
            end
        end
        tests++;
        if (both_hi !== 1'b0) begin fails++; $display("FAIL %s_rd_wr_overlap: got 1 want 0", nm); end
    endtask

    task automatic test_basic();     run_seq("basic", 0, -1, 1, 0, 0, 4, 32'h5); endtask
    task automatic test_waitstate(); run_seq("waitstate", 3, -1, 1, 0, 0, 4, 32'h5); endtask
    task automatic test_mismatch();  run_seq("mismatch", 0, 2, 1, 0, 0, 4, 32'h5); endtask
    task automatic test_timeout();   run_seq("timeout", 0, -1, 0, 0, 0, 4, 32'h5); endtask
    task automatic test_back_to_back(); run_seq("rerun", 1, -1, 1, 1, 1, 2, 32'h9); endtask

    task automatic test_illegal(input logic [2:0] nf);
        obs_q.delete();
        @(negedge clk);
        nfac_i = nf; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        tests++;
        if (busy_o !== 1'b1 || err_o !== 2'd0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL illegal%0d_cycle1: got busy=%0b err=%0d done=%0b want 1,0,0", nf, busy_o, err_o, done_o);
        end
        @(negedge clk);
        tests++;
        if (done_o !== 1'b1 || err_o !== 2'd3 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL illegal%0d_cycle2: got done=%0b err=%0d busy=%0b want 1,3,0", nf, done_o, err_o, busy_o);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL illegal%0d_accesses: got %0d want 0", nf, obs_q.size()); end
    endtask

    task automatic test_reset_midop();
        int  dc0;
        bit  seen;
        wait_n = 0; stall9 = 1'b1; corrupt_en = 1'b0;
        @(negedge clk);
        size_i = 32'd256; nfac_i = 3'd4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (m_write && m_address == 4'd9) seen = 1;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL midop_reach_fac1: got no write to 9 want one"); end
        repeat (2) @(negedge clk);
        dc0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (m_write !== 1'b0 || m_read !== 1'b0 || busy_o !== 1'b0 || m_byteenable !== 4'd0) begin
            fails++;
            $display("FAIL midop_async_drop: got wr=%0b rd=%0b busy=%0b be=%0h want 0", m_write, m_read, busy_o, m_byteenable);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0; stall9 = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (done_cnt != dc0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL midop_no_done: got done pulses=%0d busy=%0b want 0,0", done_cnt - dc0, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitstate();
        test_mismatch();
        test_timeout();
        test_illegal(3'd0);
        test_illegal(3'd5);
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
